// File: rtl/i2c_target_regbank.sv
// I2C target with a small byte register bank: START/STOP decode, 7-bit address match,
// pointer-based writes/reads with auto-increment, plus a local bank access port.
module i2c_target_regbank #(
  parameter logic [6:0]  TargetAddr = 7'h42,
  parameter int unsigned NRegs      = 8,
  parameter int unsigned Aw         = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  input  logic [Aw-1:0] loc_addr_i,
  input  logic [7:0]    loc_wdata_i,
  input  logic          loc_we_i,
  output logic [7:0]    loc_rdata_o,
  output logic          i2c_wr_pulse_o,
  output logic [Aw-1:0] i2c_wr_addr_o,
  output logic          busy_o
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  state_e        state_q;
  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_prev_q, sda_prev_q;
  logic [3:0]    cnt_q;
  logic [7:0]    shift_q;
  logic [Aw-1:0] ptr_q;
  logic          ack_q;
  logic          sda_oe_q, busy_q, wr_pulse_q;
  logic [Aw-1:0] wr_addr_q;
  logic [7:0]    loc_rdata_q;
  logic [7:0]    bank_q [NRegs];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Synchronizers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      ack_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      loc_rdata_q <= '0;
      for (int i = 0; i < NRegs; i++) bank_q[i] <= '0;
    end else begin
      wr_pulse_q  <= 1'b0;
      loc_rdata_q <= bank_q[loc_addr_i];
      // Local write first: an I2C write to the same index later in this block wins.
      if (loc_we_i) bank_q[loc_addr_i] <= loc_wdata_i;
      if (stop_det) begin
        state_q  <= StIdle;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= StAddr;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          StAddr, StPtr: begin
            shift_q <= {shift_q[6:0], sda_s};
            cnt_q   <= cnt_q + 4'd1;
          end
          StWdata: begin
            shift_q <= {shift_q[6:0], sda_s};
            cnt_q   <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              bank_q[ptr_q] <= {shift_q[6:0], sda_s};
              wr_pulse_q    <= 1'b1;
              wr_addr_q     <= ptr_q;
              ptr_q         <= ptr_q + Aw'(1);
            end
          end
          StRdata:    cnt_q <= cnt_q + 4'd1;
          StRdataAck: ack_q <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          StAddr: begin
            if (cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (shift_q[7:1] == TargetAddr) begin
                state_q  <= StAddrAck;
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
              end else begin
                state_q <= StIgnore;
                busy_q  <= 1'b0;
              end
            end
          end
          StAddrAck: begin
            cnt_q <= '0;
            if (shift_q[0]) begin
              state_q  <= StRdata;
              shift_q  <= bank_q[ptr_q];
              sda_oe_q <= ~bank_q[ptr_q][7];
              ptr_q    <= ptr_q + Aw'(1);
            end else begin
              state_q  <= StPtr;
              sda_oe_q <= 1'b0;
            end
          end
          StPtr: begin
            if (cnt_q == 4'd8) begin
              ptr_q    <= shift_q[Aw-1:0];
              sda_oe_q <= 1'b1;
              state_q  <= StPtrAck;
              cnt_q    <= '0;
            end
          end
          StPtrAck, StWdataAck: begin
            sda_oe_q <= 1'b0;
            state_q  <= StWdata;
            cnt_q    <= '0;
          end
          StWdata: begin
            if (cnt_q == 4'd8) begin
              sda_oe_q <= 1'b1;
              state_q  <= StWdataAck;
              cnt_q    <= '0;
            end
          end
          StRdata: begin
            if (cnt_q == 4'd8) begin
              sda_oe_q <= 1'b0;
              state_q  <= StRdataAck;
              cnt_q    <= '0;
            end else begin
              shift_q  <= {shift_q[6:0], 1'b1};
              sda_oe_q <= ~shift_q[6];
            end
          end
          StRdataAck: begin
            cnt_q <= '0;
            if (!ack_q) begin
              state_q  <= StRdata;
              shift_q  <= bank_q[ptr_q];
              sda_oe_q <= ~bank_q[ptr_q][7];
              ptr_q    <= ptr_q + Aw'(1);
            end else begin
              state_q  <= StIgnore;
              sda_oe_q <= 1'b0;
              busy_q   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o       = sda_oe_q;
  assign loc_rdata_o    = loc_rdata_q;
  assign i2c_wr_pulse_o = wr_pulse_q;
  assign i2c_wr_addr_o  = wr_addr_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Bench for i2c_target_regbank: local-port vector table plus directed I2C transactions
// driven by an open-drain controller model (SCL scaled to 40 clk per bit).
module tb_i2c_target_regbank;

  localparam int unsigned Q = 10;  // clk cycles per quarter SCL bit

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_ctrl, sda_ctrl, sda_line;
  logic       sda_oe, i2c_wr_pulse, busy, loc_we;
  logic [2:0] loc_addr, i2c_wr_addr;
  logic [7:0] loc_wdata, loc_rdata;

  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_target_regbank #(
    .TargetAddr(7'h42),
    .NRegs     (8),
    .Aw        (3)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .scl_i         (scl_ctrl),
    .sda_i         (sda_line),
    .sda_oe_o      (sda_oe),
    .loc_addr_i    (loc_addr),
    .loc_wdata_i   (loc_wdata),
    .loc_we_i      (loc_we),
    .loc_rdata_o   (loc_rdata),
    .i2c_wr_pulse_o(i2c_wr_pulse),
    .i2c_wr_addr_o (i2c_wr_addr),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus monitors: cumulative counts, only ever written here.
  logic [2:0] wr_log[$];
  int oe_cnt   = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (i2c_wr_pulse) wr_log.push_back(i2c_wr_addr);
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic qtr();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic drv, output logic smp);
    qtr();
    sda_ctrl = drv;
    qtr();
    scl_ctrl = 1'b1;
    qtr();
    smp = sda_line;
    qtr();
    scl_ctrl = 1'b0;
  endtask

  task automatic i2c_start();
    qtr(); sda_ctrl = 1'b0;
    qtr(); scl_ctrl = 1'b0;
  endtask

  task automatic i2c_rstart();
    qtr(); sda_ctrl = 1'b1;
    qtr(); scl_ctrl = 1'b1;
    qtr(); sda_ctrl = 1'b0;
    qtr(); scl_ctrl = 1'b0;
  endtask

  task automatic i2c_stop();
    qtr(); sda_ctrl = 1'b0;
    qtr(); scl_ctrl = 1'b1;
    qtr(); sda_ctrl = 1'b1;
    qtr();
  endtask

  // Optionally asserts loc_we in the exact cycle the target commits the 8th bit.
  task automatic write_byte(input logic [7:0] b, input logic col, input logic [2:0] caddr,
                            input logic [7:0] cdata, output logic ack);
    logic smp;
    for (int i = 7; i >= 1; i--) clock_bit(b[i], smp);
    if (col) begin
      qtr();
      sda_ctrl = b[0];
      qtr();
      scl_ctrl = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      loc_addr  = caddr;
      loc_wdata = cdata;
      loc_we    = 1'b1;
      @(posedge clk);
      #1;
      chk("collide_align", i2c_wr_pulse, 1);
      loc_we = 1'b0;
      repeat (Q - 3) @(posedge clk);
      #1;
      qtr();
      scl_ctrl = 1'b0;
    end else begin
      clock_bit(b[0], smp);
    end
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, smp);
      b[i] = smp;
    end
    clock_bit(ack_bit, smp);
  endtask

  logic [7:0] model [8];

  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) begin
      loc_addr = 3'(i);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk($sformatf("%s_bank%0d", tag, i), loc_rdata, model[i]);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_first;
    logic [7:0] exp_second;
  } loc_vec_t;

  initial begin
    loc_vec_t   vecs[6];
    logic       ack;
    logic [7:0] rd;
    int         base, oe0, busy0;

    vecs[0] = '{1'b0, 3'd0, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 3'd1, 8'h3C, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 3'd1, 8'hC3, 8'h3C, 8'hC3};
    vecs[3] = '{1'b0, 3'd1, 8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{1'b1, 3'd7, 8'hFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b0, 3'd6, 8'h00, 8'h00, 8'h00};

    rst = 1'b1; scl_ctrl = 1'b1; sda_ctrl = 1'b1;
    loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_pulse", i2c_wr_pulse, 0);
    chk("rst_wr_addr", i2c_wr_addr, 0);
    chk("rst_loc_rdata", loc_rdata, 0);
    rst = 1'b0;
    qtr();

    for (int i = 0; i < 6; i++) begin
      loc_we = vecs[i].we; loc_addr = vecs[i].addr; loc_wdata = vecs[i].wdata;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_first", i), loc_rdata, vecs[i].exp_first);
      loc_we = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_second", i), loc_rdata, vecs[i].exp_second);
    end
    foreach (model[i]) model[i] = 8'h00;
    model[1] = 8'hC3;
    model[7] = 8'hFF;

    // Write two bytes from pointer 2
    base = wr_log.size(); busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack); chk("t1_ack_addr", ack, 0);
    write_byte(8'h02, 1'b0, 3'd0, 8'h00, ack); chk("t1_ack_ptr", ack, 0);
    write_byte(8'hA5, 1'b0, 3'd0, 8'h00, ack); chk("t1_ack_d0", ack, 0);
    write_byte(8'h5A, 1'b0, 3'd0, 8'h00, ack); chk("t1_ack_d1", ack, 0);
    chk("t1_busy_during", busy, 1);
    i2c_stop();
    chk("t1_busy_after", busy, 0);
    chk("t1_busy_seen", busy_cnt > busy0, 1);
    chk("t1_npulse", wr_log.size() - base, 2);
    chk("t1_pulse0", wr_log[base], 2);
    chk("t1_pulse1", wr_log[base+1], 3);
    model[2] = 8'hA5; model[3] = 8'h5A;
    check_bank("t1");

    // Set pointer, repeated start, read ACK then NACK
    base = wr_log.size();
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack); chk("t2_ack_addr", ack, 0);
    write_byte(8'h02, 1'b0, 3'd0, 8'h00, ack); chk("t2_ack_ptr", ack, 0);
    i2c_rstart();
    write_byte(8'h85, 1'b0, 3'd0, 8'h00, ack); chk("t2_ack_raddr", ack, 0);
    read_byte(1'b0, rd); chk("t2_rd0", rd, 8'hA5);
    read_byte(1'b1, rd); chk("t2_rd1", rd, 8'h5A);
    qtr();
    chk("t2_sda_released", sda_oe, 0);
    chk("t2_busy_ignore", busy, 0);
    i2c_stop();
    chk("t2_busy_after", busy, 0);
    chk("t2_npulse", wr_log.size() - base, 0);

    // Wrong address
    base = wr_log.size(); oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'h86, 1'b0, 3'd0, 8'h00, ack); chk("t3_nack_addr", ack, 1);
    write_byte(8'h01, 1'b0, 3'd0, 8'h00, ack); chk("t3_nack_b1", ack, 1);
    write_byte(8'hFF, 1'b0, 3'd0, 8'h00, ack); chk("t3_nack_b2", ack, 1);
    i2c_stop();
    chk("t3_oe_never", oe_cnt - oe0, 0);
    chk("t3_busy_never", busy_cnt - busy0, 0);
    chk("t3_npulse", wr_log.size() - base, 0);
    check_bank("t3");

    // Pointer wrap, then pointer upper bits discarded
    base = wr_log.size();
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h07, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h11, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h22, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h33, 1'b0, 3'd0, 8'h00, ack); chk("t4_ack_last", ack, 0);
    i2c_stop();
    chk("t4_npulse", wr_log.size() - base, 3);
    chk("t4_pulse0", wr_log[base], 7);
    chk("t4_pulse1", wr_log[base+1], 0);
    chk("t4_pulse2", wr_log[base+2], 1);
    model[7] = 8'h11; model[0] = 8'h22; model[1] = 8'h33;
    check_bank("t4");
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h0B, 1'b0, 3'd0, 8'h00, ack);
    i2c_rstart();
    write_byte(8'h85, 1'b0, 3'd0, 8'h00, ack);
    read_byte(1'b1, rd); chk("t4_ptr_mask_rd", rd, 8'h5A);
    i2c_stop();

    // Collisions: same index (I2C wins), different index (both land)
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h02, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h77, 1'b1, 3'd2, 8'hEE, ack); chk("t5_ack0", ack, 0);
    write_byte(8'h99, 1'b1, 3'd5, 8'h5C, ack); chk("t5_ack1", ack, 0);
    i2c_stop();
    model[2] = 8'h77; model[3] = 8'h99; model[5] = 8'h5C;
    check_bank("t5");

    // Reset while driving a 0 read bit (bank[0]=22, MSB 0)
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack);
    write_byte(8'h00, 1'b0, 3'd0, 8'h00, ack);
    i2c_rstart();
    write_byte(8'h85, 1'b0, 3'd0, 8'h00, ack);
    qtr();
    chk("t6_oe_before_rst", sda_oe, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_oe_after_rst", sda_oe, 0);
    chk("t6_busy_after_rst", busy, 0);
    scl_ctrl = 1'b1; sda_ctrl = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    qtr();
    foreach (model[i]) model[i] = 8'h00;
    check_bank("t6_clr");
    base = wr_log.size();
    i2c_start();
    write_byte(8'h84, 1'b0, 3'd0, 8'h00, ack); chk("t6_ack_addr", ack, 0);
    write_byte(8'h04, 1'b0, 3'd0, 8'h00, ack); chk("t6_ack_ptr", ack, 0);
    write_byte(8'h3D, 1'b0, 3'd0, 8'h00, ack); chk("t6_ack_d", ack, 0);
    i2c_stop();
    chk("t6_npulse", wr_log.size() - base, 1);
    chk("t6_pulse0", wr_log[base], 4);
    model[4] = 8'h3D;
    check_bank("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
